// File: rtl/phy_tx_flit_splitter_if.sv
// Flit-side and beat-side ready/valid bundles for the PHY TX flit splitter.
// Latency: none, these are plain signal bundles.
// Backpressure: the ready signal flows from the slave modport to the master modport.

// Whole-flit handshake: one FLIT_BYTES payload per accepted transfer.
interface phy_tx_flit_if #(
    parameter int FLIT_BYTES = 64
);
    logic                    in_valid;
    logic                    in_ready;
    logic [FLIT_BYTES*8-1:0] in_bits;

    modport master (output in_valid, output in_bits, input in_ready);
    modport slave  (input in_valid, input in_bits, output in_ready);
endinterface

// 16-lane byte beat handshake, wired straight to the PHY per-lane byte inputs.
interface phy_tx_beat_if;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] out_bits_0;
    logic [7:0] out_bits_1;
    logic [7:0] out_bits_2;
    logic [7:0] out_bits_3;
    logic [7:0] out_bits_4;
    logic [7:0] out_bits_5;
    logic [7:0] out_bits_6;
    logic [7:0] out_bits_7;
    logic [7:0] out_bits_8;
    logic [7:0] out_bits_9;
    logic [7:0] out_bits_10;
    logic [7:0] out_bits_11;
    logic [7:0] out_bits_12;
    logic [7:0] out_bits_13;
    logic [7:0] out_bits_14;
    logic [7:0] out_bits_15;

    modport master (
        output out_valid, output out_last,
        output out_bits_0, output out_bits_1, output out_bits_2, output out_bits_3,
        output out_bits_4, output out_bits_5, output out_bits_6, output out_bits_7,
        output out_bits_8, output out_bits_9, output out_bits_10, output out_bits_11,
        output out_bits_12, output out_bits_13, output out_bits_14, output out_bits_15,
        input  out_ready
    );
    modport slave (
        input  out_valid, input out_last,
        input  out_bits_0, input out_bits_1, input out_bits_2, input out_bits_3,
        input  out_bits_4, input out_bits_5, input out_bits_6, input out_bits_7,
        input  out_bits_8, input out_bits_9, input out_bits_10, input out_bits_11,
        input  out_bits_12, input out_bits_13, input out_bits_14, input out_bits_15,
        output out_ready
    );
endinterface

// File: rtl/phy_tx_flit_splitter.sv
// Splits FLIT_BYTES flits into FLIT_BYTES/16 beats of 16 lane bytes for the PHY TX user port.
// Latency: first beat is presented the cycle after the flit is accepted; back-to-back flits have no bubble.
// Backpressure: out_ready low freezes the current beat; in_ready only rises when idle or on an accepted last beat.
module phy_tx_flit_splitter #(
    parameter int FLIT_BYTES = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    phy_tx_flit_if.slave     in_if,
    phy_tx_beat_if.master    out_if,
    output logic             busy,
    output logic [CNT_W-1:0] flit_count
);
    localparam int BEATS = FLIT_BYTES / 16;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [BEATS-1:0][127:0]  flit_q, flit_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [15:0][7:0]         out_bits_q, out_bits_d;

    logic beat_is_last;
    logic beat_acc;
    logic in_acc;

    assign beat_is_last = (beat_q == LAST_BEAT);
    assign beat_acc     = (state_q == SEND) & out_if.out_ready;

    // The out_ready term lets the next flit load in the same cycle the last beat leaves.
    assign in_if.in_ready = reset & ((state_q == IDLE) |
                                     ((state_q == SEND) & out_if.out_ready & beat_is_last));
    assign in_acc = in_if.in_valid & in_if.in_ready;

    // Next-state: load flits, advance beats, count completed flits, derive registered outputs.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        flit_d  = flit_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_acc) begin
                    flit_d  = in_if.in_bits;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat_acc) begin
                    if (!beat_is_last) begin
                        beat_d = beat_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (in_acc) begin
                            flit_d = in_if.in_bits;
                            beat_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
        endcase
        out_valid_d = (state_d == SEND);
        out_last_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
        out_bits_d  = flit_d[beat_d];
    end

    // State and output registers; reset discards any partially sent flit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            flit_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bits_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            flit_q      <= flit_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_bits_q  <= out_bits_d;
        end
    end

    assign busy       = (state_q == SEND);
    assign flit_count = cnt_q;

    assign out_if.out_valid   = out_valid_q;
    assign out_if.out_last    = out_last_q;
    assign out_if.out_bits_0  = out_bits_q[0];
    assign out_if.out_bits_1  = out_bits_q[1];
    assign out_if.out_bits_2  = out_bits_q[2];
    assign out_if.out_bits_3  = out_bits_q[3];
    assign out_if.out_bits_4  = out_bits_q[4];
    assign out_if.out_bits_5  = out_bits_q[5];
    assign out_if.out_bits_6  = out_bits_q[6];
    assign out_if.out_bits_7  = out_bits_q[7];
    assign out_if.out_bits_8  = out_bits_q[8];
    assign out_if.out_bits_9  = out_bits_q[9];
    assign out_if.out_bits_10 = out_bits_q[10];
    assign out_if.out_bits_11 = out_bits_q[11];
    assign out_if.out_bits_12 = out_bits_q[12];
    assign out_if.out_bits_13 = out_bits_q[13];
    assign out_if.out_bits_14 = out_bits_q[14];
    assign out_if.out_bits_15 = out_bits_q[15];
endmodule

// File: doc/phy_tx_flit_splitter.md
Name: phy_tx_flit_splitter

Overview:
- Upstream feeder for the PHY test harness TX user port (io_tx_user_rxData_*).
- Accepts whole flits of FLIT_BYTES bytes on a ready/valid input.
- Emits each flit as FLIT_BYTES/16 consecutive 16-lane x 8-bit beats on a ready/valid output that connects directly to the PHY's 16 per-lane byte inputs.
- Holds one flit in a register and sustains back-to-back flits with no bubble cycles.

Parameters:
- FLIT_BYTES, 64, flit size in bytes; must be a multiple of 16 and at least 16. BEATS = FLIT_BYTES/16.
- CNT_W, 16, width of the transmitted-flit counter.

Ports:
- clock  input  1  single block clock, rising edge.
- reset  input  1  asynchronous, active-low reset; all state clears while reset is low.
- in_valid  input  1  upstream flit valid.
- in_ready  output  1  block can accept a flit this cycle.
- in_bits  input  FLIT_BYTES*8  flit payload; byte n is in_bits[8n+7:8n].
- out_valid  output  1  beat valid; drives PHY rxData_valid.
- out_ready  input  1  PHY accepts the beat; driven by PHY rxData_ready.
- out_bits_0 .. out_bits_15  output  8 each  lane bytes of the current beat.
- out_last  output  1  current beat is the final beat of its flit.
- busy  output  1  a flit is held (state SEND).
- flit_count  output  CNT_W  number of flits fully transmitted, wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, beat=0, out_valid=0, out_last=0, busy=0, flit_count=0.
  - Flit register and out_bits_* cleared to 0.
  - in_ready is forced 0 while reset is low.
- FSM has two states:
  - IDLE: out_valid=0, in_ready=1. When in_valid=1, on the clock edge: capture in_bits, beat<=0, go to SEND.
  - SEND: out_valid=1, out_bits_j = flit[(beat*16+j)*8 +: 8], out_last=(beat==BEATS-1). A beat is accepted when out_valid & out_ready.
    - Accepted and not last: beat<=beat+1.
    - Accepted and last: flit_count<=flit_count+1. Then:
      - if in_valid=1 the same cycle: capture the new flit, beat<=0, stay in SEND;
      - otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==SEND & out_ready & beat==BEATS-1). This is a combinational path from out_ready; it is accepted by design so back-to-back flits have zero bubble.
- Latency: first beat of a flit appears on out_* the cycle after input acceptance. A flit takes BEATS accepted beats.
- Output stability: once out_valid=1, out_bits_* and out_last stay stable until that beat is accepted. out_valid never drops without acceptance.
- Stall: out_ready=0 holds beat, data and state indefinitely; in_ready=0 for the whole stall.
- beat counter width is clog2(BEATS), minimum 1 bit. When BEATS=1, every beat is last and beat stays 0.
- flit_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-flit: the partial flit is discarded and no further beats of it are emitted. After release the block is in IDLE with flit_count=0.
- in_valid=1 while in_ready=0 has no effect. The upstream holds the flit; this block never drops or duplicates a flit.

Test Plan:
- Reset release, in_valid=0 for 10 cycles -> out_valid=0, in_ready=1, busy=0, flit_count=0 throughout.
- One flit, byte n = n (0x00..0x3F), out_ready=1 -> next 4 cycles:
  - beat0 lanes 0x00..0x0F, beat1 0x10..0x1F, beat2 0x20..0x2F, beat3 0x30..0x3F;
  - out_last only on beat3; flit_count=1; IDLE after.
- Four flits back-to-back (all bytes = 1, 2, 3, 4 respectively), in_valid held, out_ready=1 -> 16 consecutive valid beats with no gap; in_ready pulses only on each beat3; flit_count=4.
- out_ready toggling 1,0,0,1,... during a flit -> each beat held unchanged while out_ready=0; beat order and values identical to the unstalled case; no duplicated beats.
- Reset driven low after beat1 is accepted, then released -> out_valid=0 immediately (asynchronously), flit_count=0; a new flit afterwards starts at beat0.
- CNT_W=2, six flits sent -> flit_count sequence 1,2,3,0,1,2.
